// File: rtl/mips16_pkg.sv
// Shared types and constants for the mips16 memory-side blocks.
package mips16_pkg;

    // Native machine word.
    typedef logic [15:0] word_t;

    // Access sequencer states of the data memory responder.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Byte address where software posts its final result.
    localparam word_t MAILBOX_ADDR_DEFAULT = 16'd84;

endpackage

// File: rtl/dmem_ram.sv
// Word-wide data RAM: synchronous write, asynchronous read, no reset.
module dmem_ram
    import mips16_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    word_t mem [DEPTH_WORDS];

    // Store port: write the addressed word on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_resp.sv
// Data memory responder: accepts one load/store, inserts wait states,
// answers with a one-cycle memready pulse; also hosts the result mailbox
// and a saturating count of completed stores.
//
// Handshake: in IDLE a request is taken on any rising edge that sees
// memreq=1, and memwrite/dataadr/writedata are captured on that same edge.
// memreq is ignored until the sequencer is back in IDLE. The access is
// performed on the edge that ends RESP; memready, readdata and err are
// valid together for the single following cycle and are zero otherwise.
module data_mem_resp
    import mips16_pkg::*;
#(
    parameter int          DEPTH_WORDS  = 64,
    parameter int          WAIT_CYCLES  = 1,
    parameter logic [15:0] MAILBOX_ADDR = MAILBOX_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq,
    input  logic        memwrite,
    input  logic [15:0] dataadr,
    input  logic [15:0] writedata,
    output logic        memready,
    output logic [15:0] readdata,
    output logic        err,
    output logic        done,
    output logic [15:0] result,
    output logic [15:0] store_count
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [15:0] DEPTH_L = 16'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        lat_write;
    word_t       lat_adr;
    word_t       lat_wdata;

    logic [14:0] word_idx;
    logic        is_mbox;
    logic        in_range;
    logic        fault;
    logic        ram_we;
    word_t       ram_rdata;

    // Decode of the captured address: mailbox hit, RAM range, alignment.
    assign word_idx = lat_adr[15:1];
    assign is_mbox  = (lat_adr == MAILBOX_ADDR);
    assign in_range = ({1'b0, word_idx} < DEPTH_L);
    assign fault    = !is_mbox && (lat_adr[0] || !in_range);
    assign ram_we   = (state == ST_RESP) && lat_write && !fault && !is_mbox;

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (word_idx[AW-1:0]),
        .wdata (lat_wdata),
        .rdata (ram_rdata)
    );

    // Access sequencer with registered response, mailbox and store counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            wait_cnt    <= 4'd0;
            lat_write   <= 1'b0;
            lat_adr     <= '0;
            lat_wdata   <= '0;
            memready    <= 1'b0;
            readdata    <= '0;
            err         <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            store_count <= '0;
        end else begin
            memready <= 1'b0;
            readdata <= '0;
            err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (memreq) begin
                        lat_write <= memwrite;
                        lat_adr   <= dataadr;
                        lat_wdata <= writedata;
                        if (WAIT_L == 4'd0) begin
                            state <= ST_RESP;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_L;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                    if (wait_cnt <= 4'd1) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state    <= ST_IDLE;
                    memready <= 1'b1;
                    err      <= fault;
                    if (!fault && !lat_write) begin
                        readdata <= is_mbox ? result : ram_rdata;
                    end
                    if (!fault && lat_write) begin
                        if (is_mbox) begin
                            result <= lat_wdata;
                            done   <= 1'b1;
                        end
                        if (store_count != 16'hFFFF) begin
                            store_count <= store_count + 16'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: table of single accesses on a WAIT_CYCLES=1
// instance, plus hand sequences for back-to-back zero-wait traffic,
// reset during a wait state and store counter saturation.
module tb_data_mem_resp;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // WAIT_CYCLES = 1 instance
    logic        memreq = 1'b0, memwrite = 1'b0;
    logic [15:0] dataadr = '0, writedata = '0;
    logic        memready, err, done;
    logic [15:0] readdata, result, store_count;

    // WAIT_CYCLES = 0 instance
    logic        memreq_z = 1'b0, memwrite_z = 1'b0;
    logic [15:0] dataadr_z = '0, writedata_z = '0;
    logic        memready_z, err_z, done_z;
    logic [15:0] readdata_z, result_z, store_count_z;

    data_mem_resp #(.DEPTH_WORDS(64), .WAIT_CYCLES(1), .MAILBOX_ADDR(16'd84)) u_dut (
        .clk(clk), .reset(reset), .memreq(memreq), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata), .memready(memready),
        .readdata(readdata), .err(err), .done(done), .result(result),
        .store_count(store_count)
    );

    data_mem_resp #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .MAILBOX_ADDR(16'd84)) u_dut_z (
        .clk(clk), .reset(reset), .memreq(memreq_z), .memwrite(memwrite_z),
        .dataadr(dataadr_z), .writedata(writedata_z), .memready(memready_z),
        .readdata(readdata_z), .err(err_z), .done(done_z), .result(result_z),
        .store_count(store_count_z)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- stimulus table ----------------
    typedef struct {
        logic        wr;
        logic [15:0] adr;
        logic [15:0] wd;
        logic [15:0] rd;
        logic        er;
        logic        dn;
        logic [15:0] res;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    // One access on the WAIT_CYCLES=1 instance; memreq drops right after
    // the accept edge, the response must still arrive two edges later.
    task automatic access(input string tag, input logic wr, input logic [15:0] adr,
                          input logic [15:0] wd, input logic [15:0] exp_rd,
                          input logic exp_er, input logic exp_dn,
                          input logic [15:0] exp_res, input logic [15:0] exp_cnt);
        int lat;
        lat = 0;
        @(negedge clk);
        memreq = 1'b1; memwrite = wr; dataadr = adr; writedata = wd;
        @(posedge clk); #1;
        memreq = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (memready) begin
                lat = i;
                break;
            end
        end
        chk({tag, " latency"}, 16'(lat), 16'd2);
        chk({tag, " readdata"}, readdata, exp_rd);
        chk({tag, " err"}, {15'd0, err}, {15'd0, exp_er});
        chk({tag, " done"}, {15'd0, done}, {15'd0, exp_dn});
        chk({tag, " result"}, result, exp_res);
        chk({tag, " store_count"}, store_count, exp_cnt);
        @(posedge clk); #1;
        chk({tag, " memready pulse width"}, {15'd0, memready}, 16'd0);
        chk({tag, " readdata idle"}, readdata, 16'd0);
        chk({tag, " err idle"}, {15'd0, err}, 16'd0);
    endtask

    logic [15:0] pre42;

    initial begin
        //         wr    adr       wd        rd        er    dn    res       cnt
        vecs[0]  = '{1'b1, 16'h0010, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'd1};
        vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'd1};
        vecs[2]  = '{1'b1, 16'h0054, 16'h0007, 16'h0000, 1'b0, 1'b1, 16'h0007, 16'd2};
        vecs[3]  = '{1'b0, 16'h0054, 16'h0000, 16'h0007, 1'b0, 1'b1, 16'h0007, 16'd2};
        vecs[4]  = '{1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0007, 16'd2};
        vecs[5]  = '{1'b1, 16'h0080, 16'hAAAA, 16'h0000, 1'b1, 1'b1, 16'h0007, 16'd2};
        vecs[6]  = '{1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0, 1'b1, 16'h0007, 16'd2};
        vecs[7]  = '{1'b1, 16'h007E, 16'hCAFE, 16'h0000, 1'b0, 1'b1, 16'h0007, 16'd3};
        vecs[8]  = '{1'b0, 16'h007E, 16'h0000, 16'hCAFE, 1'b0, 1'b1, 16'h0007, 16'd3};
        vecs[9]  = '{1'b1, 16'h8000, 16'h00FF, 16'h0000, 1'b1, 1'b1, 16'h0007, 16'd3};
        vecs[10] = '{1'b1, 16'h0000, 16'h0001, 16'h0000, 1'b0, 1'b1, 16'h0007, 16'd4};
        vecs[11] = '{1'b0, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'h0007, 16'd4};
        vecs[12] = '{1'b1, 16'h0054, 16'h0009, 16'h0000, 1'b0, 1'b1, 16'h0009, 16'd5};
        vecs[13] = '{1'b0, 16'h0054, 16'h0000, 16'h0009, 1'b0, 1'b1, 16'h0009, 16'd5};
        vecs[14] = '{1'b0, 16'h0080, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0009, 16'd5};
        vecs[15] = '{1'b1, 16'h0011, 16'hBBBB, 16'h0000, 1'b1, 1'b1, 16'h0009, 16'd5};
        vecs[16] = '{1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0, 1'b1, 16'h0009, 16'd5};
        vecs[17] = '{1'b1, 16'h0020, 16'h1111, 16'h0000, 1'b0, 1'b1, 16'h0009, 16'd6};
        vecs[18] = '{1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0, 1'b1, 16'h0009, 16'd6};
        vecs[19] = '{1'b0, 16'hFFFE, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0009, 16'd6};

        // ---- reset values, with the zero-wait instance already requesting ----
        memreq_z = 1'b1; memwrite_z = 1'b1; dataadr_z = 16'd84; writedata_z = 16'h0042;
        repeat (3) @(posedge clk);
        #1;
        chk("reset memready", {15'd0, memready}, 16'd0);
        chk("reset readdata", readdata, 16'd0);
        chk("reset err", {15'd0, err}, 16'd0);
        chk("reset done", {15'd0, done}, 16'd0);
        chk("reset result", result, 16'd0);
        chk("reset store_count", store_count, 16'd0);
        chk("reset memready_z", {15'd0, memready_z}, 16'd0);

        // ---- zero-wait, memreq held high: pulse on every second cycle ----
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b memready cycle %0d", k), {15'd0, memready_z},
                (k % 2 == 1) ? 16'd1 : 16'd0);
        end
        chk("b2b store_count", store_count_z, 16'd5);
        chk("b2b done", {15'd0, done_z}, 16'd1);
        chk("b2b result", result_z, 16'h0042);
        memreq_z = 1'b0;

        // ---- table of single accesses ----
        pre42 = u_dut.u_ram.mem[42];
        for (int i = 0; i < NV; i++) begin
            access($sformatf("vec%0d", i), vecs[i].wr, vecs[i].adr, vecs[i].wd,
                   vecs[i].rd, vecs[i].er, vecs[i].dn, vecs[i].res, vecs[i].cnt);
        end
        chk("mailbox store leaves word 42", u_dut.u_ram.mem[42], pre42);

        // ---- reset while a store sits in WAIT ----
        @(negedge clk);
        memreq = 1'b1; memwrite = 1'b1; dataadr = 16'h0020; writedata = 16'hBEEF;
        @(posedge clk); #1;
        memreq = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
        #2;
        reset = 1'b0;
        #1;
        chk("abort memready", {15'd0, memready}, 16'd0);
        chk("abort readdata", readdata, 16'd0);
        chk("abort err", {15'd0, err}, 16'd0);
        chk("abort done", {15'd0, done}, 16'd0);
        chk("abort result", result, 16'd0);
        chk("abort store_count", store_count, 16'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("abort no pulse %0d", k), {15'd0, memready}, 16'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        access("after abort", 1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0, 1'b0, 16'h0000, 16'd0);

        // ---- store counter saturation, preloaded just below the top ----
        @(negedge clk);
        force u_dut.store_count = 16'hFFFE;
        @(negedge clk);
        release u_dut.store_count;
        access("sat1", 1'b1, 16'h0000, 16'h2222, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hFFFF);
        access("sat2", 1'b1, 16'h0000, 16'h3333, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hFFFF);
        access("sat3", 1'b0, 16'h0000, 16'h0000, 16'h3333, 1'b0, 1'b0, 16'h0000, 16'hFFFF);

        // ---- final report ----
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, number of 16-bit RAM words (power of two, 2..32768).
REQ-002 Parameter WAIT_CYCLES, default 1, extra wait states per access (0..15).
REQ-003 Parameter MAILBOX_ADDR, default 16'd84, byte address of the result mailbox.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: memreq  input  1  access request from the processor.
REQ-007 Port: memwrite  input  1  1=store, 0=load; valid with memreq.
REQ-008 Port: dataadr  input  16  byte address; valid with memreq.
REQ-009 Port: writedata  input  16  store data; valid with memreq.
REQ-010 Port: memready  output  1  one-cycle completion pulse.
REQ-011 Port: readdata  output  16  load data; valid only while memready=1.
REQ-012 Port: err  output  1  access fault; valid only while memready=1.
REQ-013 Port: done  output  1  sticky: mailbox has been written.
REQ-014 Port: result  output  16  last value stored to the mailbox.
REQ-015 Port: store_count  output  16  count of completed non-faulting stores, saturating at 16'hFFFF.

Function
REQ-016 States: IDLE, WAIT, RESP; encoded as shared enum.
REQ-017 IDLE: memreq=1 at a clock edge accepts the request; memwrite/dataadr/writedata latched that edge.
REQ-018 Accept -> WAIT with wait counter = WAIT_CYCLES; WAIT_CYCLES=0 -> directly to RESP.
REQ-019 WAIT: counter decrements each cycle; at 0 -> RESP.
REQ-020 RESP: memready=1 for exactly one cycle, then IDLE.
REQ-021 Latency accept-edge to memready high = WAIT_CYCLES+1 cycles.
REQ-022 memreq ignored in WAIT and RESP; earliest next accept is the edge ending the RESP cycle's successor (back-to-back period = WAIT_CYCLES+2).
REQ-023 memreq dropped after accept does not cancel the access.
REQ-024 Word index = latched dataadr[15:1]; fault if dataadr[0]=1 or index >= DEPTH_WORDS (except mailbox).
REQ-025 Faulting access: err=1 in RESP, RAM unchanged, readdata=0, store_count unchanged.
REQ-026 Store to MAILBOX_ADDR: RAM not written; result<=writedata, done<=1 at the RESP edge; counts as store; no fault even if out of RAM range.
REQ-027 Load from MAILBOX_ADDR returns result.
REQ-028 Non-faulting store writes RAM at the RESP edge; a load issued next returns the new value.
REQ-029 readdata=0 and err=0 whenever memready=0.
REQ-030 done stays 1 until reset; later mailbox stores update result only.

Reset
REQ-031 reset=0 forces, asynchronously: state IDLE, counter 0, memready 0, readdata 0, err 0, done 0, result 0, store_count 0.
REQ-032 Reset mid-access aborts it; no RAM write occurs for the aborted store.
REQ-033 RAM contents not reset.
REQ-034 First accept possible on the first rising edge after reset deasserts.

Structure
REQ-035 Shared package mips16_pkg holds state enum, 16-bit word type, default MAILBOX_ADDR constant.
REQ-036 One sub-module dmem_ram: synchronous-write, asynchronous-read DEPTH_WORDS x 16 array.

Verification
REQ-037 WAIT_CYCLES=1: store 0x1234 @ 0x0010, load 0x0010 -> memready 2 cycles after each accept, readdata=0x1234, err=0.
REQ-038 Store 7 @ 84 -> done=1, result=7, RAM word 42 unchanged, store_count+1.
REQ-039 Load @ 0x0011 and store @ 2*DEPTH_WORDS -> err=1, readdata=0, RAM and store_count unchanged.
REQ-040 memreq held high continuously with WAIT_CYCLES=0 -> memready every 2nd cycle, one access per pulse.
REQ-041 reset low during WAIT of store 0xBEEF @ 0x0020 -> memready never pulses, word 0x0020 keeps old value, outputs at reset values.
REQ-042 65536 stores -> store_count saturates at 0xFFFF.
